// File: rtl/ex_mem_reg.sv
// Y86-64 execute/memory boundary: condition codes, jXX/cmovXX evaluation, cmov dest gating, M pipeline register.
// Latency: e_cnd/e_dstE_eff combinational; M_* and cc_* one cycle after the E inputs.
// Backpressure: M_stall holds M (and blocks CC writes); M_bubble loads a NOP; stall wins over bubble.
module ex_mem_reg #(
    parameter int W      = 64,
    parameter int STAT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [STAT_W-1:0] e_stat,
    input  logic [3:0]        e_icode,
    input  logic [3:0]        e_ifun,
    input  logic [W-1:0]      e_valE,
    input  logic [W-1:0]      e_valA,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic              alu_zf,
    input  logic              alu_sf,
    input  logic              alu_of,
    input  logic              m_exc,
    input  logic              w_exc,
    input  logic              M_stall,
    input  logic              M_bubble,
    output logic              cc_zf,
    output logic              cc_sf,
    output logic              cc_of,
    output logic              e_cnd,
    output logic [3:0]        e_dstE_eff,
    output logic [STAT_W-1:0] M_stat,
    output logic [3:0]        M_icode,
    output logic              M_cnd,
    output logic [W-1:0]      M_valE,
    output logic [W-1:0]      M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM
);

    localparam logic [STAT_W-1:0] STAT_AOK   = STAT_W'(1);
    localparam logic [3:0]        ICODE_NOP  = 4'h1;
    localparam logic [3:0]        ICODE_CMOV = 4'h2;
    localparam logic [3:0]        ICODE_OPQ  = 4'h6;
    localparam logic [3:0]        ICODE_JXX  = 4'h7;
    localparam logic [3:0]        REG_NONE   = 4'hF;

    logic              r_cc_zf;
    logic              r_cc_sf;
    logic              r_cc_of;
    logic [STAT_W-1:0] r_m_stat;
    logic [3:0]        r_m_icode;
    logic              r_m_cnd;
    logic [W-1:0]      r_m_valE;
    logic [W-1:0]      r_m_valA;
    logic [3:0]        r_m_dstE;
    logic [3:0]        r_m_dstM;

    logic              w_cond;
    logic              w_uses_cond;
    logic              w_e_cnd;
    logic [3:0]        w_dstE_eff;
    logic              w_set_cc;

    // Condition table evaluated from the architectural CC only (no bypass from the ALU flags).
    always_comb begin
        w_cond = 1'b0;
        case (e_ifun)
            4'h0:    w_cond = 1'b1;
            4'h1:    w_cond = (r_cc_sf ^ r_cc_of) | r_cc_zf;
            4'h2:    w_cond = r_cc_sf ^ r_cc_of;
            4'h3:    w_cond = r_cc_zf;
            4'h4:    w_cond = ~r_cc_zf;
            4'h5:    w_cond = ~(r_cc_sf ^ r_cc_of);
            4'h6:    w_cond = ~(r_cc_sf ^ r_cc_of) & ~r_cc_zf;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_uses_cond = (e_icode == ICODE_CMOV) || (e_icode == ICODE_JXX);
    assign w_e_cnd     = w_uses_cond & w_cond;
    // A cmov whose condition fails must not appear to write anything, including to forwarding.
    assign w_dstE_eff  = ((e_icode == ICODE_CMOV) && !w_e_cnd) ? REG_NONE : e_dstE;

    // Flags only commit for a clean OPq that is actually advancing and with no older exception in flight.
    assign w_set_cc = (e_icode == ICODE_OPQ) && (e_stat == STAT_AOK)
                      && !m_exc && !w_exc && !M_stall;

    // Condition-code register; reset value ZF=1, SF=0, OF=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc_zf <= 1'b1;
            r_cc_sf <= 1'b0;
            r_cc_of <= 1'b0;
        end else if (w_set_cc) begin
            r_cc_zf <= alu_zf;
            r_cc_sf <= alu_sf;
            r_cc_of <= alu_of;
        end
    end

    // M pipeline register: stall holds, bubble inserts a NOP, otherwise capture execute results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_stat  <= STAT_AOK;
            r_m_icode <= ICODE_NOP;
            r_m_cnd   <= 1'b0;
            r_m_valE  <= '0;
            r_m_valA  <= '0;
            r_m_dstE  <= REG_NONE;
            r_m_dstM  <= REG_NONE;
        end else if (M_stall) begin
            r_m_stat  <= r_m_stat;
            r_m_icode <= r_m_icode;
            r_m_cnd   <= r_m_cnd;
            r_m_valE  <= r_m_valE;
            r_m_valA  <= r_m_valA;
            r_m_dstE  <= r_m_dstE;
            r_m_dstM  <= r_m_dstM;
        end else if (M_bubble) begin
            r_m_stat  <= STAT_AOK;
            r_m_icode <= ICODE_NOP;
            r_m_cnd   <= 1'b0;
            r_m_valE  <= '0;
            r_m_valA  <= '0;
            r_m_dstE  <= REG_NONE;
            r_m_dstM  <= REG_NONE;
        end else begin
            r_m_stat  <= e_stat;
            r_m_icode <= e_icode;
            r_m_cnd   <= w_e_cnd;
            r_m_valE  <= e_valE;
            r_m_valA  <= e_valA;
            r_m_dstE  <= w_dstE_eff;
            r_m_dstM  <= e_dstM;
        end
    end

    assign cc_zf      = r_cc_zf;
    assign cc_sf      = r_cc_sf;
    assign cc_of      = r_cc_of;
    assign e_cnd      = w_e_cnd;
    assign e_dstE_eff = w_dstE_eff;
    assign M_stat     = r_m_stat;
    assign M_icode    = r_m_icode;
    assign M_cnd      = r_m_cnd;
    assign M_valE     = r_m_valE;
    assign M_valA     = r_m_valA;
    assign M_dstE     = r_m_dstE;
    assign M_dstM     = r_m_dstM;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg: directed Y86 scenarios checked against an instruction-level model every cycle.
// Latency: model tracks one-cycle E->M and next-cycle CC visibility.
// Backpressure: exercises stall, bubble, stall+bubble and async reset mid-operation.
module tb_ex_mem_reg;

    localparam int W = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    e_stat;
    logic [3:0]    e_icode;
    logic [3:0]    e_ifun;
    logic [W-1:0]  e_valE;
    logic [W-1:0]  e_valA;
    logic [3:0]    e_dstE;
    logic [3:0]    e_dstM;
    logic          alu_zf, alu_sf, alu_of;
    logic          m_exc, w_exc;
    logic          M_stall, M_bubble;
    logic          cc_zf, cc_sf, cc_of;
    logic          e_cnd;
    logic [3:0]    e_dstE_eff;
    logic [2:0]    M_stat;
    logic [3:0]    M_icode;
    logic          M_cnd;
    logic [W-1:0]  M_valE;
    logic [W-1:0]  M_valA;
    logic [3:0]    M_dstE;
    logic [3:0]    M_dstM;

    int n_chk  = 0;
    int n_fail = 0;

    ex_mem_reg #(.W(W), .STAT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .e_stat(e_stat), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
        .m_exc(m_exc), .w_exc(w_exc), .M_stall(M_stall), .M_bubble(M_bubble),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .e_cnd(e_cnd), .e_dstE_eff(e_dstE_eff),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Architectural meaning of each Y86 condition: le, l, e, ne, ge, g on signed compare flags.
    function automatic logic cond_holds(input logic [3:0] ifun, input logic z, input logic s, input logic o);
        logic less;
        less = (s != o);
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return less || z;
            4'd2:    return less;
            4'd3:    return z;
            4'd4:    return !z;
            4'd5:    return !less;
            4'd6:    return !less && !z;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic exp_cnd(input logic [3:0] icode, input logic [3:0] ifun,
                                     input logic z, input logic s, input logic o);
        if (icode == 4'd2 || icode == 4'd7) return cond_holds(ifun, z, s, o);
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_dst(input logic [3:0] icode, input logic c, input logic [3:0] d);
        if (icode == 4'd2 && !c) return 4'hF;
        return d;
    endfunction

    logic         mz = 1'b1, ms = 1'b0, mo = 1'b0;
    logic [2:0]   mm_stat = 3'd1;
    logic [3:0]   mm_icode = 4'h1;
    logic         mm_cnd = 1'b0;
    logic [63:0]  mm_valE = '0, mm_valA = '0;
    logic [3:0]   mm_dstE = 4'hF, mm_dstM = 4'hF;
    logic         nc;
    logic [3:0]   nd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mz = 1'b1; ms = 1'b0; mo = 1'b0;
            mm_stat = 3'd1; mm_icode = 4'h1; mm_cnd = 1'b0;
            mm_valE = '0; mm_valA = '0; mm_dstE = 4'hF; mm_dstM = 4'hF;
        end else begin
            nc = exp_cnd(e_icode, e_ifun, mz, ms, mo);
            nd = exp_dst(e_icode, nc, e_dstE);
            if (!M_stall) begin
                if (e_icode == 4'd6 && e_stat == 3'd1 && !m_exc && !w_exc) begin
                    mz = alu_zf; ms = alu_sf; mo = alu_of;
                end
                if (M_bubble) begin
                    mm_stat = 3'd1; mm_icode = 4'h1; mm_cnd = 1'b0;
                    mm_valE = '0; mm_valA = '0; mm_dstE = 4'hF; mm_dstM = 4'hF;
                end else begin
                    mm_stat = e_stat; mm_icode = e_icode; mm_cnd = nc;
                    mm_valE = e_valE; mm_valA = e_valA; mm_dstE = nd; mm_dstM = e_dstM;
                end
            end
        end
    end

    // Compare every cycle, mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic c;
        c = exp_cnd(e_icode, e_ifun, mz, ms, mo);
        chk("cc_zf", 64'(cc_zf), 64'(mz));
        chk("cc_sf", 64'(cc_sf), 64'(ms));
        chk("cc_of", 64'(cc_of), 64'(mo));
        chk("e_cnd", 64'(e_cnd), 64'(c));
        chk("e_dstE_eff", 64'(e_dstE_eff), 64'(exp_dst(e_icode, c, e_dstE)));
        chk("M_stat", 64'(M_stat), 64'(mm_stat));
        chk("M_icode", 64'(M_icode), 64'(mm_icode));
        chk("M_cnd", 64'(M_cnd), 64'(mm_cnd));
        chk("M_valE", M_valE, mm_valE);
        chk("M_valA", M_valA, mm_valA);
        chk("M_dstE", 64'(M_dstE), 64'(mm_dstE));
        chk("M_dstM", 64'(M_dstM), 64'(mm_dstM));
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        e_stat = 3'd1; e_icode = 4'h1; e_ifun = 4'h0;
        e_valE = '0; e_valA = '0; e_dstE = 4'hF; e_dstM = 4'hF;
        alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0;
        m_exc = 1'b0; w_exc = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
    endtask

    task automatic instr(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] valE,
                         input logic [3:0] dstE);
        idle();
        e_icode = icode; e_ifun = ifun; e_valE = valE; e_valA = valE ^ 64'hFF; e_dstE = dstE;
        e_dstM = 4'hF;
    endtask

    task automatic opq(input logic z, input logic s, input logic o);
        instr(4'h6, 4'h1, 64'h55, 4'h2);
        alu_zf = z; alu_sf = s; alu_of = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        // T1: reset state
        tick();
        #2;
        chk("rst_cc_zf", 64'(cc_zf), 64'd1);
        chk("rst_M_icode", 64'(M_icode), 64'h1);
        chk("rst_M_dstE", 64'(M_dstE), 64'hF);
        chk("rst_M_stat", 64'(M_stat), 64'd1);
        tick();
        rst_n = 1'b1;

        // T2: subq producing SF=1, then jle sees it
        opq(1'b0, 1'b1, 1'b0);
        tick();
        chk("t2_cc_sf", 64'(cc_sf), 64'd1);
        chk("t2_cc_zf", 64'(cc_zf), 64'd0);
        instr(4'h7, 4'h1, 64'h100, 4'hF);
        #1;
        chk("t2_jle_cnd", 64'(e_cnd), 64'd1);
        tick();
        chk("t2_M_cnd", 64'(M_cnd), 64'd1);
        chk("t2_M_icode", 64'(M_icode), 64'h7);

        // T3: ZF=0 -> cmove suppressed, cmovne writes
        instr(4'h2, 4'h3, 64'h42, 4'h3);
        #1;
        chk("t3_cmove_eff", 64'(e_dstE_eff), 64'hF);
        tick();
        chk("t3_cmove_M_dstE", 64'(M_dstE), 64'hF);
        instr(4'h2, 4'h4, 64'h43, 4'h3);
        tick();
        chk("t3_cmovne_M_dstE", 64'(M_dstE), 64'h3);

        // T4: CC frozen by exceptions
        opq(1'b1, 1'b0, 1'b0);
        tick();
        chk("t4_zf_set", 64'(cc_zf), 64'd1);
        opq(1'b0, 1'b1, 1'b1); m_exc = 1'b1;
        tick();
        chk("t4_m_exc_zf", 64'(cc_zf), 64'd1);
        opq(1'b0, 1'b1, 1'b1); w_exc = 1'b1;
        tick();
        chk("t4_w_exc_zf", 64'(cc_zf), 64'd1);
        opq(1'b0, 1'b1, 1'b1); e_stat = 3'd3;
        tick();
        chk("t4_adr_zf", 64'(cc_zf), 64'd1);
        chk("t4_adr_M_stat", 64'(M_stat), 64'd3);

        // T5: stall beats bubble, then bubble alone
        instr(4'h3, 4'h0, 64'h1234, 4'h5);
        tick();
        chk("t5_load", M_valE, 64'h1234);
        for (int i = 0; i < 2; i++) begin
            opq(1'b0, 1'b1, 1'b0);
            e_valE = 64'h9999 + 64'(i);
            M_stall = 1'b1; M_bubble = 1'b1;
            tick();
            chk("t5_stall_valE", M_valE, 64'h1234);
            chk("t5_stall_cc_zf", 64'(cc_zf), 64'd1);
        end
        instr(4'h3, 4'h0, 64'hABCD, 4'h5);
        M_bubble = 1'b1;
        tick();
        chk("t5_bubble_icode", 64'(M_icode), 64'h1);
        chk("t5_bubble_valE", M_valE, 64'h0);

        // T6: undefined ifun never taken, unconditional always taken
        for (int f = 7; f < 16; f++) begin
            instr(4'h7, 4'(f), 64'h0, 4'hF);
            #1;
            chk("t6_jxx_undef", 64'(e_cnd), 64'd0);
            tick();
        end
        for (int k = 0; k < 8; k++) begin
            opq(k[0], k[1], k[2]);
            tick();
            instr(4'h2, 4'h0, 64'(k), 4'h4);
            #1;
            chk("t6_rrmovq", 64'(e_cnd), 64'd1);
            tick();
            // sweep every jXX condition against this flag setting; the per-cycle compare checks them
            for (int f = 1; f < 7; f++) begin
                instr(4'h7, 4'(f), 64'(f), 4'hF);
                tick();
            end
            instr(4'h6, 4'h0, 64'h0, 4'h1);
            m_exc = 1'b1;
            tick();
        end

        // Async reset mid-operation, under stall
        instr(4'h3, 4'h0, 64'h7777, 4'h6);
        tick();
        M_stall = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_M_valE", M_valE, 64'h0);
        chk("arst_M_dstE", 64'(M_dstE), 64'hF);
        chk("arst_cc_zf", 64'(cc_zf), 64'd1);
        tick();
        rst_n = 1'b1;
        idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
